// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the bypassing register file and its busy scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Register 0 is hardwired: never written, never busy, always reads zero.
    function automatic logic is_zero_reg(input logic [31:0] addr);
        return (addr == 32'd0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-writeback tracking plus a registered popcount of the busy bits.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    localparam logic [AW:0] CNT_ONE = 1;

    logic             set_v;
    logic             clr_v;
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        set_v    = set_en && !is_zero_reg(32'(set_idx));
        clr_v    = clr_en && !is_zero_reg(32'(clr_idx));
        busy_nxt = busy;
        // Clear first so an issue in the same cycle (the newer producer) wins.
        if (clr_v) busy_nxt[clr_idx] = 1'b0;
        if (set_v) busy_nxt[set_idx] = 1'b1;
        inc = set_v && !busy[set_idx];
        dec = clr_v && busy[clr_idx] && !(set_v && (set_idx == clr_idx));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            case ({inc, dec})
                2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
                2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Parametrised integer register file with write-to-read bypass and a busy scoreboard.
// WE and ISSUE_EN are single-cycle qualifiers sampled at the rising edge; there is no handshake.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NRP*AW-1:0] RADDR,
    output logic [NRP*XLEN-1:0] RDATA,
    output logic [NRP-1:0]    RBUSY,
    input  logic              WE,
    input  logic [AW-1:0]     WADDR,
    input  logic [XLEN-1:0]   WDATA,
    input  logic              ISSUE_EN,
    input  logic [AW-1:0]     ISSUE_RD,
    output logic [AW:0]       BUSY_CNT
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_v;
    logic [AW-1:0]    ra;

    assign wr_v = WE && !is_zero_reg(32'(WADDR));

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .CLK      (CLK),
        .RST      (RST),
        .set_en   (ISSUE_EN),
        .set_idx  (ISSUE_RD),
        .clr_en   (WE),
        .clr_idx  (WADDR),
        .busy     (busy),
        .busy_cnt (BUSY_CNT)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_v) begin
            regs[WADDR] <= WDATA;
        end
    end

    // A writeback in flight to the same register both supplies the data and resolves the hazard.
    always_comb begin
        RDATA = '0;
        RBUSY = '0;
        ra    = '0;
        for (int p = 0; p < NRP; p++) begin
            ra = RADDR[p*AW +: AW];
            if (!is_zero_reg(32'(ra))) begin
                if (wr_v && (WADDR == ra)) begin
                    RDATA[p*XLEN +: XLEN] = WDATA;
                end else begin
                    RDATA[p*XLEN +: XLEN] = regs[ra];
                    RBUSY[p]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed and randomized checks of two regfile_bypass_sb configurations against a behavioural model.
module tb_regfile_bypass_sb;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // default configuration: XLEN=32, NREGS=32, NRP=2
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [5:0]  busy_cnt;

    // variant configuration: XLEN=64, NREGS=16, NRP=3
    logic [11:0]  raddr_b;
    logic [191:0] rdata_b;
    logic [2:0]   rbusy_b;
    logic         we_b;
    logic [3:0]   waddr_b;
    logic [63:0]  wdata_b;
    logic         issue_en_b;
    logic [3:0]   issue_rd_b;
    logic [4:0]   busy_cnt_b;

    regfile_bypass_sb u_dut (
        .CLK(CLK), .RST(RST), .RADDR(raddr), .RDATA(rdata), .RBUSY(rbusy),
        .WE(we), .WADDR(waddr), .WDATA(wdata), .ISSUE_EN(issue_en),
        .ISSUE_RD(issue_rd), .BUSY_CNT(busy_cnt)
    );

    regfile_bypass_sb #(.XLEN(64), .NREGS(16), .NRP(3)) u_dut_b (
        .CLK(CLK), .RST(RST), .RADDR(raddr_b), .RDATA(rdata_b), .RBUSY(rbusy_b),
        .WE(we_b), .WADDR(waddr_b), .WDATA(wdata_b), .ISSUE_EN(issue_en_b),
        .ISSUE_RD(issue_rd_b), .BUSY_CNT(busy_cnt_b)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_reg   [32];
    bit          m_busy  [32];
    logic [63:0] m_reg_b [16];
    bit          m_busy_b[16];
    logic [63:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    function automatic int pop_a();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic int pop_b();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_busy_b[i]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0; issue_en = 1'b0; issue_rd = '0;
        we_b = 1'b0; waddr_b = '0; wdata_b = '0; issue_en_b = 1'b0; issue_rd_b = '0;
    endtask

    // Advance one edge, applying the architectural rules to the model with the inputs seen there.
    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
            for (int i = 0; i < 16; i++) begin m_reg_b[i] = '0; m_busy_b[i] = 0; end
        end else begin
            if (we && waddr != 0) begin m_reg[waddr] = wdata; m_busy[waddr] = 0; end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
            if (we_b && waddr_b != 0) begin m_reg_b[waddr_b] = wdata_b; m_busy_b[waddr_b] = 0; end
            if (issue_en_b && issue_rd_b != 0) m_busy_b[issue_rd_b] = 1;
        end
        @(negedge CLK);
    endtask

    // ---------------- scoreboard checks ----------------
    task automatic check_a(input string tag);
        logic [4:0] a;
        bit eb;
        for (int p = 0; p < 2; p++) begin
            a = raddr[p*5 +: 5];
            if (a == 0) begin exp_q.push_back(64'd0); eb = 0; end
            else if (we && waddr == a) begin exp_q.push_back({32'd0, wdata}); eb = 0; end
            else begin exp_q.push_back({32'd0, m_reg[a]}); eb = m_busy[a]; end
            check({tag, "_rdata"}, {32'd0, rdata[p*32 +: 32]}, exp_q.pop_front());
            check({tag, "_rbusy"}, {63'd0, rbusy[p]}, {63'd0, eb});
        end
        check({tag, "_cnt"}, {58'd0, busy_cnt}, 64'(pop_a()));
    endtask

    task automatic check_b(input string tag);
        logic [3:0] a;
        bit eb;
        for (int p = 0; p < 3; p++) begin
            a = raddr_b[p*4 +: 4];
            if (a == 0) begin exp_q.push_back(64'd0); eb = 0; end
            else if (we_b && waddr_b == a) begin exp_q.push_back(wdata_b); eb = 0; end
            else begin exp_q.push_back(m_reg_b[a]); eb = m_busy_b[a]; end
            check({tag, "_rdata_b"}, rdata_b[p*64 +: 64], exp_q.pop_front());
            check({tag, "_rbusy_b"}, {63'd0, rbusy_b[p]}, {63'd0, eb});
        end
        check({tag, "_cnt_b"}, {59'd0, busy_cnt_b}, 64'(pop_b()));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        RST = 1'b1;
        raddr = '0; raddr_b = '0;
        idle_inputs();
        @(negedge CLK);
        tick();
        RST = 1'b0;

        // preload every register nonzero and mark some busy
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'h1000_0000 | 32'(i);
            issue_en = 1'b1; issue_rd = 5'(31 - i);
            we_b = (i < 16); waddr_b = 4'(i); wdata_b = 64'hABCD_0000_0000_0000 | 64'(i);
            issue_en_b = 1'b1; issue_rd_b = 4'(16 - (i % 16));
            tick();
        end
        // reset wins over a simultaneous write/issue
        we = 1'b1; waddr = 5'd4; wdata = 32'h5555_5555; issue_en = 1'b1; issue_rd = 5'd6;
        do_reset();
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            raddr_b = {3{4'(a)}};
            #1;
            check("rst_rdata", rdata, 64'd0);
            check("rst_rbusy", {62'd0, rbusy}, 64'd0);
            check("rst_rdata_b", rdata_b[63:0], 64'd0);
            check("rst_rbusy_b", {61'd0, rbusy_b}, 64'd0);
            check("rst_cnt", {58'd0, busy_cnt}, 64'd0);
            check("rst_cnt_b", {59'd0, busy_cnt_b}, 64'd0);
            tick();
        end

        // bypass in the write cycle, stored value on the next
        raddr = {5'd5, 5'd5};
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        #1;
        check("byp_rdata", rdata, 64'hDEAD_BEEF_DEAD_BEEF);
        check("byp_rbusy", {62'd0, rbusy}, 64'd0);
        tick();
        we = 1'b0;
        #1;
        check("byp_next_rdata", rdata, 64'hDEAD_BEEF_DEAD_BEEF);
        check_a("byp_next");

        // scoreboard: issue 7 then 9, then write 7
        issue_en = 1'b1; issue_rd = 5'd7; tick();
        check("sb_cnt1", {58'd0, busy_cnt}, 64'd1);
        issue_rd = 5'd9; tick();
        check("sb_cnt2", {58'd0, busy_cnt}, 64'd2);
        issue_en = 1'b0; raddr = {5'd9, 5'd7};
        #1;
        check("sb_rbusy7", {62'd0, rbusy}, 64'd3);
        we = 1'b1; waddr = 5'd7; wdata = 32'h11;
        tick();
        we = 1'b0;
        #1;
        check("sb_cnt_after_wr", {58'd0, busy_cnt}, 64'd1);
        check("sb_rdata7", {32'd0, rdata[31:0]}, 64'h11);
        check("sb_rbusy7_clr", {63'd0, rbusy[0]}, 64'd0);

        // simultaneous issue + write to register 3
        do_reset();
        raddr = {5'd3, 5'd3};
        we = 1'b1; waddr = 5'd3; wdata = 32'h22; issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        check("sim_cnt", {58'd0, busy_cnt}, 64'd1);
        tick();
        idle_inputs();
        #1;
        check("sim_rep_cnt", {58'd0, busy_cnt}, 64'd1);
        check("sim_rdata", rdata, 64'h0000_0022_0000_0022);
        check("sim_rbusy", {62'd0, rbusy}, 64'd3);

        // register 0 ignores writes and issues
        raddr = '0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; issue_en = 1'b1; issue_rd = 5'd0;
        #1;
        check("r0_byp_rdata", rdata, 64'd0);
        tick();
        idle_inputs();
        #1;
        check("r0_rdata", rdata, 64'd0);
        check("r0_rbusy", {62'd0, rbusy}, 64'd0);
        check("r0_cnt", {58'd0, busy_cnt}, 64'd1);

        // wide variant: write reg 15, read on all ports next cycle
        do_reset();
        we_b = 1'b1; waddr_b = 4'd15; wdata_b = 64'h0123_4567_89AB_CDEF;
        tick();
        we_b = 1'b0; raddr_b = 12'hFFF;
        #1;
        for (int p = 0; p < 3; p++)
            check("var_rd15", rdata_b[p*64 +: 64], 64'h0123_4567_89AB_CDEF);
        for (int r = 1; r < 16; r++) begin
            issue_en_b = 1'b1; issue_rd_b = 4'(r);
            tick();
        end
        check("var_cnt15", {59'd0, busy_cnt_b}, 64'd15);
        issue_rd_b = 4'd5;
        tick();
        issue_en_b = 1'b0;
        #1;
        check("var_cnt15_hold", {59'd0, busy_cnt_b}, 64'd15);
        check_b("var_full");

        // randomized traffic on both instances, narrow address range for collisions
        do_reset();
        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 60) == 0);
            we = ($urandom_range(0, 2) != 0); waddr = 5'($urandom_range(0, 7)); wdata = $urandom;
            issue_en = ($urandom_range(0, 1) != 0); issue_rd = 5'($urandom_range(0, 7));
            raddr = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
            we_b = ($urandom_range(0, 2) != 0); waddr_b = 4'($urandom_range(0, 15));
            wdata_b = {$urandom, $urandom};
            issue_en_b = ($urandom_range(0, 3) != 0); issue_rd_b = 4'($urandom_range(0, 15));
            raddr_b = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            #1;
            check_a("rand");
            check_b("rand");
            tick();
        end
        RST = 1'b0;
        idle_inputs();
        #1;
        check_a("final");
        check_b("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised integer register file: the next generation of the core's 32x32 two-read/one-write file. Width, depth and read-port count are parameters. Adds a same-cycle write-to-read bypass and a per-register busy scoreboard, so the pipeline can detect pending writebacks without its own tracking. Sits in decode; reads feed the ID/EX latch, the write port is driven from writeback, and the issue port is driven when an instruction with a destination register enters execute.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, >=2)
- NRP, 2, number of read ports
- AW, $clog2(NREGS), register address width (derived, do not override)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- RADDR  in  NRP*AW  read addresses, port p at bits [p*AW +: AW]
- RDATA  out  NRP*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- RBUSY  out  NRP  port p's register has a pending writeback
- WE  in  1  writeback enable
- WADDR  in  AW  writeback register
- WDATA  in  XLEN  writeback data
- ISSUE_EN  in  1  mark ISSUE_RD as pending
- ISSUE_RD  in  AW  destination register being issued
- BUSY_CNT  out  AW+1  number of registers currently busy

## Operation
- Register 0 reads as zero on every port and is never busy. Writes to it and issues to it are ignored.
- Read (combinational, per port p, address a):
  - a==0: RDATA=0, RBUSY=0.
  - Bypass case, WE && WADDR==a && a!=0: RDATA=WDATA and RBUSY=0 (that writeback resolves the hazard).
  - Otherwise: RDATA=reg[a], RBUSY=busy[a].
- Write: at a rising edge with WE && WADDR!=0, reg[WADDR] becomes WDATA and busy[WADDR] is cleared.
- Issue: at a rising edge with ISSUE_EN && ISSUE_RD!=0, busy[ISSUE_RD] is set.
- Issue and write to the same register in the same cycle:
  - The write data is stored.
  - Busy ends set, because the new producer wins.
  - BUSY_CNT does not change if the register was already busy.
- Issue to a register that is already busy: it stays busy and BUSY_CNT is unchanged.
- Write to a register that is not busy: the data is stored and BUSY_CNT is unchanged.
- BUSY_CNT is a registered counter equal to the popcount of the busy bits. Per cycle it changes by (new sets) minus (clears), which is in {-1, 0, +1}. It never wraps; the maximum is NREGS-1.
- Reset clears all registers to 0, all busy bits to 0 and BUSY_CNT to 0. Reset overrides any WE or ISSUE_EN in the same cycle.

## Timing
- Read latency is 0 cycles. RDATA and RBUSY are combinational from RADDR, the register/busy state and the bypass inputs.
- Write and issue take effect at the clock edge. Stored state is visible one cycle later, and the bypass covers the write cycle itself.
- BUSY_CNT updates at the same edge as the busy bits and is a registered output.
- After RST deasserts, the first edge may write or issue; there is no warm-up.
- RST asserted mid-operation, with busy bits set: at the next edge everything is zero, including busy bits and BUSY_CNT.
- There is no handshake. WE and ISSUE_EN are single-cycle qualifiers.

## Structure
- Shared package `regfile_pkg`:
  - default XLEN and NREGS constants
  - a function for the zero-register check
  - a localparam for the AW derivation
- One sub-module, `rf_scoreboard`, holding:
  - the busy bit vector
  - the set/clear priority logic
  - the BUSY_CNT counter
- The top level holds the data array, the read muxes and the bypass logic.

## Test plan
- Reset with every register preloaded to nonzero: after one RST edge, every RADDR reads 0 with RBUSY=0, and BUSY_CNT=0.
- Bypass: with WE=1, WADDR=5, WDATA=0xDEADBEEF, and RADDR port0=5, port1=5 in the same cycle, both ports read 0xDEADBEEF with RBUSY=0. On the next cycle with WE=0, both still read 0xDEADBEEF.
- Scoreboard: issue to 7, then 9:
  - BUSY_CNT goes 1 then 2, and reading 7 gives RBUSY=1.
  - Write 7 with 0x11: BUSY_CNT=1, and reading 7 gives 0x11 with RBUSY=0.
- Simultaneous events on register 3, with 3 not busy: ISSUE_RD=3 and WADDR=3 with WDATA=0x22 in the same cycle:
  - Afterwards reg3=0x22, busy3=1, BUSY_CNT=1.
  - Repeating the same cycle with 3 already busy leaves BUSY_CNT at 1.
- Register 0: WE to 0 with 0xFFFFFFFF and ISSUE to 0 give read 0, RBUSY=0, BUSY_CNT unchanged.
- Parameter variant with XLEN=64, NREGS=16, NRP=3:
  - Write 0x0123456789ABCDEF to register 15 and read it on all three ports in the following cycle.
  - Issue registers 1 to 15: BUSY_CNT reaches 15 with no overflow.
